// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver sampling mid-bit; each good byte leaves as a one-cycle out_en pulse.
// Latency HALF+9*(MAX+1)+3 cycles from pin fall to out_en; no backpressure, so the consumer must take every pulse.
module uart_rx #(
    parameter int BAUD    = 9600,
    parameter int SYS_CLK = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_data,
    output logic [7:0] out_data,
    output logic       out_en,
    output logic       out_err
);

    localparam int MAX   = SYS_CLK / BAUD - 1;
    localparam int HALF  = MAX / 2;
    localparam int WIDTH = $clog2(MAX + 1);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] HALF_C = WIDTH'(HALF);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    if (MAX < 3) begin : g_max_check
        $error("uart_rx: SYS_CLK/BAUD must be at least 4");
    end

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             prev_q, prev_d;
    logic [1:0]       fill_q, fill_d;
    logic             armed_q, armed_d;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cnt_inc;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_en_q, out_en_d;
    logic             out_err_q, out_err_d;

    assign cnt_inc  = cnt_q + 1'b1;
    assign out_data = out_data_q;
    assign out_en   = out_en_q;
    assign out_err  = out_err_q;

    always_comb begin
        s1_d       = in_data;
        s2_d       = s1_q;
        prev_d     = s2_q;
        // s2 only reflects the real pin two cycles after reset; until then the
        // line has not genuinely been seen high, so no start may be armed.
        fill_d     = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        armed_d    = armed_q | ((fill_q == 2'd2) & s2_q);
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        out_data_d = out_data_q;
        out_en_d   = 1'b0;
        out_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && prev_q && !s2_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // Decide in the cycle cnt steps onto HALF so the start bit is
                // sampled HALF cycles after the edge was first seen.
                cnt_d = cnt_inc;
                if (cnt_inc == HALF_C) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    state_d = s2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == MAX_C) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = s2_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                if (cnt_q == MAX_C) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (s2_q) begin
                        out_data_d = shreg_q;
                        out_en_d   = 1'b1;
                    end else begin
                        out_err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            prev_q     <= 1'b1;
            fill_q     <= 2'd0;
            armed_q    <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shreg_q    <= 8'h00;
            out_data_q <= 8'h00;
            out_en_q   <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            prev_q     <= prev_d;
            fill_q     <= fill_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            out_err_q  <= out_err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames (directed plus random) and compares every out_en/out_err pulse
// against a frame-level model predicting pulse cycle, kind and byte.
module tb_uart_rx;

    localparam int SYS_CLK = 50_000_000;
    localparam int BAUD    = 5_000_000;
    localparam int MAX     = SYS_CLK / BAUD - 1;
    localparam int HALF    = MAX / 2;
    localparam int BITC    = MAX + 1;
    // Pin driven in cycle p: two synchronizer stages, HALF to mid start bit,
    // nine more bit times to mid stop bit, one registered output cycle.
    localparam int LAT     = HALF + 9 * BITC + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_data;
    logic [7:0] out_data;
    logic       out_en;
    logic       out_err;

    uart_rx #(.BAUD(BAUD), .SYS_CLK(SYS_CLK)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .out_data (out_data),
        .out_en   (out_en),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    typedef struct {
        int         t;
        bit         err;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_q[$];
    int         obs_t[$];
    logic [7:0] last_good = 8'h00;
    bit         pulse_prev = 1'b0;

    always @(negedge clk) begin : monitor
        ev_t e;
        if (out_en || out_err) begin
            check("exclusive", int'(out_en & out_err), 0);
            check("no_consecutive", int'(pulse_prev), 0);
            obs_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_cycle", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.t);
                check("pulse_is_err", int'(out_err), int'(e.err));
                check("out_data", int'(out_data), e.err ? int'(last_good) : int'(e.d));
                if (!e.err) last_good = e.d;
            end
        end
        pulse_prev = out_en | out_err;
    end

    task automatic idle(input logic lvl, input int n);
        in_data = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural transmitter; rst_at >= 0 pulses rst at that cycle offset and the frame is not expected.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_at = -1);
        logic [9:0] bits;
        int k;
        bits = {stop, b, 1'b0};
        k = 0;
        if (rst_at < 0) exp_q.push_back('{cyc + LAT, !stop, b});
        for (int i = 0; i < 10; i++) begin
            in_data = bits[i];
            repeat (BITC) begin
                rst = (k == rst_at);
                if (rst) last_good = 8'h00;
                k++;
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin : stim
        int n0;
        logic [7:0] b;
        logic stop;
        rst = 1'b1;
        in_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_en", int'(out_en), 0);
        check("reset_out_err", int'(out_err), 0);
        check("reset_out_data", int'(out_data), 0);
        rst = 1'b0;
        idle(1'b1, 20);

        n0 = obs_t.size();
        send_frame(8'h55, 1'b1);
        idle(1'b1, 20);
        check("single_55_pulses", obs_t.size() - n0, 1);

        n0 = obs_t.size();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(1'b1, 20);
        check("b2b_pulses", obs_t.size() - n0, 2);
        check("b2b_spacing", obs_t[n0 + 1] - obs_t[n0], 10 * BITC);

        n0 = obs_t.size();
        idle(1'b0, 3);
        idle(1'b1, 30);
        check("glitch_no_pulse", obs_t.size() - n0, 0);
        send_frame(8'h81, 1'b1);
        idle(1'b1, 20);
        check("after_glitch_pulses", obs_t.size() - n0, 1);

        n0 = obs_t.size();
        send_frame(8'h11, 1'b1);
        send_frame(8'h3C, 1'b0);
        check("err_holds_data", int'(out_data), 8'h11);
        idle(1'b0, 50);
        check("held_low_no_pulse", obs_t.size() - n0, 2);
        idle(1'b1, 20);
        send_frame(8'h7E, 1'b1);
        idle(1'b1, 20);
        check("err_seq_pulses", obs_t.size() - n0, 3);

        n0 = obs_t.size();
        send_frame(8'hC3, 1'b1, 4 * BITC + BITC / 2);
        idle(1'b1, 20);
        check("rst_frame_no_pulse", obs_t.size() - n0, 0);
        check("rst_clears_data", int'(out_data), 0);
        send_frame(8'hC3, 1'b1);
        idle(1'b1, 20);
        check("after_rst_pulses", obs_t.size() - n0, 1);

        n0 = obs_t.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle(1'b1, 20);
        check("loopback_pulses", obs_t.size() - n0, 3);

        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 6) != 0);
            send_frame(b, stop);
            idle(1'b1, stop ? $urandom_range(0, 12) : $urandom_range(1, 12));
        end
        idle(1'b1, 30);
        check("all_expected_delivered", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
